// File: rtl/parking_occupancy_multi.sv
`default_nettype none
// ============================================================================
//  Module      : parking_occupancy_multi
//  Description : Multi-lane parking lot occupancy counter. Each lane has a
//                synchroniser, a debounce filter and a direction-detect FSM
//                that emits entry/exit/error pulses. A shared saturating
//                counter merges all lanes into the lot occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_occupancy_multi #(
    parameter int LANES    = 2,
    parameter int CAP      = 200,
    parameter int DEBOUNCE = 4,
    localparam int CNT_W   = $clog2(CAP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LANES-1:0]  a,
    input  logic [LANES-1:0]  b,
    output logic [LANES-1:0]  inc,
    output logic [LANES-1:0]  dec,
    output logic [LANES-1:0]  lane_err,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);

    // Debounce counter width and signed merge width (room for +/- LANES).
    localparam int DBW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int SW  = CNT_W + 4;
    localparam logic signed [SW-1:0] c_cap_s = SW'(CAP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_E1    = 3'd1,
        S_E2    = 3'd2,
        S_E3    = 3'd3,
        S_X1    = 3'd4,
        S_X2    = 3'd5,
        S_X3    = 3'd6,
        S_ABORT = 3'd7
    } state_t;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [LANES-1:0] w_inc;
    logic [LANES-1:0] w_dec;
    logic [LANES-1:0] w_err;

    // Reset assertion is immediate; release is delayed two clocks to stay clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [1:0]     r_sync1;
            logic [1:0]     r_sync2;
            logic [1:0]     r_filt;
            logic [1:0]     r_cand;
            logic [DBW-1:0] r_dcnt;
            state_t         r_state;
            logic           r_inc;
            logic           r_dec;
            logic           r_err;

            // Two-flop synchroniser for the asynchronous {a,b} beam pair.
            always_ff @(posedge clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_sync1 <= 2'b00;
                    r_sync2 <= 2'b00;
                end else begin
                    r_sync1 <= {a[i], b[i]};
                    r_sync2 <= r_sync1;
                end
            end

            // Debounce: accept a new level only after it held DEBOUNCE+1 samples.
            always_ff @(posedge clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_filt <= 2'b00;
                    r_cand <= 2'b00;
                    r_dcnt <= '0;
                end else if (r_sync2 == r_filt) begin
                    r_dcnt <= '0;
                end else if (r_sync2 != r_cand) begin
                    r_cand <= r_sync2;
                    r_dcnt <= DBW'(1);
                end else if (r_dcnt == DBW'(DEBOUNCE)) begin
                    r_filt <= r_cand;
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DBW'(1);
                end
            end

            // Direction FSM; pulses are registered and last a single cycle.
            always_ff @(posedge clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_state <= S_IDLE;
                    r_inc   <= 1'b0;
                    r_dec   <= 1'b0;
                    r_err   <= 1'b0;
                end else begin
                    r_inc <= 1'b0;
                    r_dec <= 1'b0;
                    r_err <= 1'b0;
                    case (r_state)
                        S_IDLE: begin
                            case (r_filt)
                                2'b10: r_state <= S_E1;
                                2'b01: r_state <= S_X1;
                                2'b11: begin r_state <= S_ABORT; r_err <= 1'b1; end
                                default: ;
                            endcase
                        end
                        S_E1: begin
                            case (r_filt)
                                2'b11: r_state <= S_E2;
                                2'b00: r_state <= S_IDLE;
                                2'b01: begin r_state <= S_ABORT; r_err <= 1'b1; end
                                default: ;
                            endcase
                        end
                        S_E2: begin
                            case (r_filt)
                                2'b01: r_state <= S_E3;
                                2'b10: r_state <= S_E1;
                                2'b00: begin r_state <= S_ABORT; r_err <= 1'b1; end
                                default: ;
                            endcase
                        end
                        S_E3: begin
                            case (r_filt)
                                2'b00: begin r_state <= S_IDLE; r_inc <= 1'b1; end
                                2'b11: r_state <= S_E2;
                                2'b10: begin r_state <= S_ABORT; r_err <= 1'b1; end
                                default: ;
                            endcase
                        end
                        S_X1: begin
                            case (r_filt)
                                2'b11: r_state <= S_X2;
                                2'b00: r_state <= S_IDLE;
                                2'b10: begin r_state <= S_ABORT; r_err <= 1'b1; end
                                default: ;
                            endcase
                        end
                        S_X2: begin
                            case (r_filt)
                                2'b10: r_state <= S_X3;
                                2'b01: r_state <= S_X1;
                                2'b00: begin r_state <= S_ABORT; r_err <= 1'b1; end
                                default: ;
                            endcase
                        end
                        S_X3: begin
                            case (r_filt)
                                2'b00: begin r_state <= S_IDLE; r_dec <= 1'b1; end
                                2'b11: r_state <= S_X2;
                                2'b01: begin r_state <= S_ABORT; r_err <= 1'b1; end
                                default: ;
                            endcase
                        end
                        default: begin
                            // ABORT: wait for both beams clear before rearming.
                            if (r_filt == 2'b00) begin
                                r_state <= S_IDLE;
                            end
                        end
                    endcase
                end
            end

            assign w_inc[i] = r_inc;
            assign w_dec[i] = r_dec;
            assign w_err[i] = r_err;
        end
    endgenerate

    assign inc      = w_inc;
    assign dec      = w_dec;
    assign lane_err = w_err;

    logic [3:0]             w_n_in;
    logic [3:0]             w_n_out;
    logic signed [SW-1:0]   w_sum;
    logic [CNT_W-1:0]       w_next;
    logic                   w_ovf;
    logic                   w_unf;
    logic [CNT_W-1:0]       r_count;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_ovf;
    logic                   r_unf;

    // Net all lane completions, then clamp to [0, CAP].
    always_comb begin
        w_n_in  = 4'd0;
        w_n_out = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            w_n_in  = w_n_in  + {3'b000, w_inc[i]};
            w_n_out = w_n_out + {3'b000, w_dec[i]};
        end
        w_sum = $signed({4'b0000, r_count})
              + $signed({{CNT_W{1'b0}}, w_n_in})
              - $signed({{CNT_W{1'b0}}, w_n_out});
        w_ovf = (w_sum > c_cap_s);
        w_unf = (w_sum < 0);
        if (w_ovf) begin
            w_next = CNT_W'(CAP);
        end else if (w_unf) begin
            w_next = '0;
        end else begin
            w_next = w_sum[CNT_W-1:0];
        end
    end

    // Occupancy register with full/empty decoded from the next value.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_full  <= (w_next == CNT_W'(CAP));
            r_empty <= (w_next == '0);
            r_ovf   <= r_ovf | w_ovf;
            r_unf   <= r_unf | w_unf;
        end
    end

    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_parking_occupancy_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_occupancy_multi
//  Description : Directed plus randomized bench for parking_occupancy_multi
//                with a behavioural lot model compared every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_occupancy_multi;

    localparam int NL  = 2;
    localparam int CAP = 3;
    localparam int D   = 4;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [NL-1:0] a, b;
    logic [NL-1:0] inc, dec, lerr;
    logic [CW-1:0] count;
    logic          full, empty, ovf, unf;

    parking_occupancy_multi #(.LANES(NL), .CAP(CAP), .DEBOUNCE(D)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .inc(inc), .dec(dec), .lane_err(lerr),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States: 0 IDLE, 1 E1, 2 E2, 3 E3, 4 X1, 5 X2, 6 X3, 7 ABORT
    // Pulse kinds: 0 none, 1 inc, 2 dec, 3 err. Index ab = {a,b}.
    int            T_NEXT [8][4];
    int            T_PUL  [8][4];
    logic [1:0]    hist   [NL][D+3];   // hist[l][j] = raw sample j edges ago
    logic [1:0]    mfilt  [NL];
    int            mst    [NL];
    logic [NL-1:0] minc, mdec, merr;
    int            mcount;
    bit            movf, munf;
    int            rel;

    task automatic set_row(input int s, input int n0, p0, n1, p1, n2, p2, n3, p3);
        T_NEXT[s][0] = n0; T_PUL[s][0] = p0;
        T_NEXT[s][1] = n1; T_PUL[s][1] = p1;
        T_NEXT[s][2] = n2; T_PUL[s][2] = p2;
        T_NEXT[s][3] = n3; T_PUL[s][3] = p3;
    endtask

    task automatic init_table();
        //          state   00      01      10      11
        set_row(0,  0,0,    4,0,    1,0,    7,3);
        set_row(1,  0,0,    7,3,    1,0,    2,0);
        set_row(2,  7,3,    3,0,    1,0,    2,0);
        set_row(3,  0,1,    3,0,    7,3,    2,0);
        set_row(4,  0,0,    4,0,    7,3,    5,0);
        set_row(5,  7,3,    4,0,    6,0,    5,0);
        set_row(6,  0,2,    7,3,    6,0,    5,0);
        set_row(7,  0,0,    7,0,    7,0,    7,0);
    endtask

    task automatic mreset();
        for (int l = 0; l < NL; l++) begin
            for (int k = 0; k < D + 3; k++) hist[l][k] = 2'b00;
            mfilt[l] = 2'b00;
            mst[l]   = 0;
        end
        minc = '0; mdec = '0; merr = '0;
        mcount = 0; movf = 0; munf = 0;
        rel = 0;
    endtask

    function automatic int popc(input logic [NL-1:0] v);
        int n = 0;
        for (int i = 0; i < NL; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_step();
        int  net, p;
        bit  same;
        if (rel < 2) begin
            rel++;                      // reset release still propagating
        end else begin
            for (int l = 0; l < NL; l++) begin
                for (int k = D + 2; k > 0; k--) hist[l][k] = hist[l][k-1];
                hist[l][0] = {a[l], b[l]};
            end
            net = mcount + popc(minc) - popc(mdec);
            if (net > CAP) begin mcount = CAP; movf = 1; end
            else if (net < 0) begin mcount = 0; munf = 1; end
            else mcount = net;
            for (int l = 0; l < NL; l++) begin
                p = T_PUL[mst[l]][int'(mfilt[l])];
                mst[l]  = T_NEXT[mst[l]][int'(mfilt[l])];
                minc[l] = (p == 1);
                mdec[l] = (p == 2);
                merr[l] = (p == 3);
            end
            // filter accepts a level seen on D+1 consecutive synchronised samples
            for (int l = 0; l < NL; l++) begin
                same = 1;
                for (int k = 3; k <= D + 2; k++)
                    if (hist[l][k] != hist[l][2]) same = 0;
                if (same) mfilt[l] = hist[l][2];
            end
        end
    endtask

    task automatic compare_all();
        chk("inc",      int'(inc),   int'(minc));
        chk("dec",      int'(dec),   int'(mdec));
        chk("lane_err", int'(lerr),  int'(merr));
        chk("count",    int'(count), mcount);
        chk("full",     int'(full),  int'(mcount == CAP));
        chk("empty",    int'(empty), int'(mcount == 0));
        chk("ovf",      int'(ovf),   int'(movf));
        chk("unf",      int'(unf),   int'(munf));
    endtask

    // Model advance and per-cycle comparison, 2 time units after each edge.
    always begin
        @(posedge clk or negedge reset);
        if (!reset) mreset();
        else        model_step();
        if (clk) begin
            #2;
            compare_all();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [1:0] ab0, input logic [1:0] ab1, input int hold);
        a = {ab1[1], ab0[1]};
        b = {ab1[0], ab0[0]};
        repeat (hold) @(negedge clk);
    endtask

    task automatic entry(input int lane);
        logic [1:0] s [4];
        s[0] = 2'b10; s[1] = 2'b11; s[2] = 2'b01; s[3] = 2'b00;
        for (int k = 0; k < 4; k++)
            if (lane == 0) step(s[k], 2'b00, 10); else step(2'b00, s[k], 10);
        repeat (6) @(negedge clk);
    endtask

    task automatic leave(input int lane);
        logic [1:0] s [4];
        s[0] = 2'b01; s[1] = 2'b11; s[2] = 2'b10; s[3] = 2'b00;
        for (int k = 0; k < 4; k++)
            if (lane == 0) step(s[k], 2'b00, 10); else step(2'b00, s[k], 10);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_err0(input string nm, input int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (lerr[0]) seen = 1;
        end
        chk(nm, int'(seen), 1);
    endtask

    function automatic logic [1:0] pat(input int dir, input int idx);
        logic [7:0] ent, ext;
        ent = 8'b10_11_01_00;
        ext = 8'b01_11_10_00;
        return (dir == 0) ? ent[7-2*idx -: 2] : ext[7-2*idx -: 2];
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int hold [NL];
        int idx  [NL];
        int dir  [NL];
        logic [1:0] v;
        init_table();
        mreset();
        a = '0; b = '0; reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full),  0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // entry on lane 0 with latency pinned: inc after 8 edges, count after 9
        step(2'b10, 2'b00, 10);
        step(2'b11, 2'b00, 10);
        step(2'b01, 2'b00, 10);
        a = '0; b = '0;
        repeat (8) @(negedge clk);
        chk("entry_inc_pulse", int'(inc[0]), 1);
        chk("entry_count_pre", int'(count), 0);
        @(negedge clk);
        chk("entry_count", int'(count), 1);
        chk("entry_empty", int'(empty), 0);
        repeat (4) @(negedge clk);

        // exit on lane 1 from 1
        leave(1);
        chk("exit_count", int'(count), 0);
        chk("exit_empty", int'(empty), 1);

        // back-out at E2 on lane 0
        step(2'b10, 2'b00, 10); step(2'b11, 2'b00, 10);
        step(2'b10, 2'b00, 10); step(2'b00, 2'b00, 14);
        chk("backout_count", int'(count), 0);

        // short glitch, then illegal 00->11
        step(2'b10, 2'b00, 3); step(2'b00, 2'b00, 14);
        a = 2'b01; b = 2'b01;
        wait_err0("illegal_err", 20);
        step(2'b00, 2'b00, 14);
        chk("illegal_count", int'(count), 0);

        // fill to CAP, then simultaneous exit (lane 0) and entry (lane 1)
        entry(0); entry(0); entry(1);
        chk("fill_count", int'(count), 3);
        chk("fill_full",  int'(full), 1);
        step(2'b01, 2'b10, 10); step(2'b11, 2'b11, 10);
        step(2'b10, 2'b01, 10); step(2'b00, 2'b00, 14);
        chk("simul_count", int'(count), 3);
        chk("simul_ovf",   int'(ovf), 0);

        // down to 1, then both lanes enter together
        leave(0); leave(1);
        chk("down_count", int'(count), 1);
        step(2'b10, 2'b10, 10); step(2'b11, 2'b11, 10);
        step(2'b01, 2'b01, 10); step(2'b00, 2'b00, 14);
        chk("both_in_count", int'(count), 3);
        chk("both_in_ovf",   int'(ovf), 0);

        // entry at capacity is dropped
        entry(0);
        chk("sat_count", int'(count), 3);
        chk("sat_full",  int'(full), 1);
        chk("sat_ovf",   int'(ovf), 1);

        // drain and underflow
        leave(0); leave(1); leave(0); leave(1);
        chk("unf_count", int'(count), 0);
        chk("unf_flag",  int'(unf), 1);

        // reset while lane 0 is in E2 with count 2
        entry(0); entry(1);
        chk("pre_rst_count", int'(count), 2);
        step(2'b10, 2'b00, 10); step(2'b11, 2'b00, 10);
        reset = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_ovf",   int'(ovf), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_err0("post_rst_err", 30);
        step(2'b00, 2'b00, 14);
        entry(0);
        chk("recover_count", int'(count), 1);

        // randomized walks, biased toward legal sequences
        for (int l = 0; l < NL; l++) begin hold[l] = 0; idx[l] = 0; dir[l] = 0; end
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                reset = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
            for (int l = 0; l < NL; l++) begin
                if (hold[l] == 0) begin
                    if ($urandom_range(0, 7) == 0) begin
                        v = 2'($urandom_range(0, 3));
                    end else begin
                        v = pat(dir[l], idx[l]);
                        idx[l]++;
                        if (idx[l] == 4) begin
                            idx[l] = 0;
                            dir[l] = int'($urandom_range(0, 1));
                        end
                    end
                    a[l] = v[1];
                    b[l] = v[0];
                    hold[l] = int'($urandom_range(2, 12));
                end else begin
                    hold[l]--;
                end
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
